// File: rtl/dmem_ctrl.sv
// Data-memory sequencer for the Y86 memory stage. Decodes the CPU request,
// arbitrates round-robin against a debug/loader port, runs a req/ready
// handshake to a variable-latency memory and reports address/timeout errors.
//
// Handshake contract: a requester raises *_req and holds it until its
// *_done pulse; the request is captured in IDLE, so later input changes are
// harmless. Towards memory, mem_en and all mem_* outputs stay stable from
// ISSUE through WAIT until a single-cycle mem_ready, or until TIMEOUT WAIT
// cycles pass, whichever comes first.
module dmem_ctrl #(
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 4096,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] valE,
    input  logic [63:0]       valA,
    input  logic [63:0]       valP,
    output logic [63:0]       cpu_valM,
    output logic              cpu_done,
    output logic              cpu_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [63:0]       dbg_wdata,
    output logic [63:0]       dbg_rdata,
    output logic              dbg_done,
    output logic              dbg_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - 8);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);

    // last_grant: 0 = CPU, 1 = DBG; also identifies the owner of the DONE pulse
    state_t            state, state_nxt;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic              we_q;
    logic [63:0]       rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              cpu_mem;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [63:0]       cpu_wdata;
    logic              grant_any;
    logic              grant_dbg;

    // Y86 memory-stage decode of the CPU request
    always_comb begin
        cpu_mem   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = valE;
        cpu_wdata = 64'd0;
        case (icode)
            4'h4:    begin cpu_we = 1'b1; cpu_wdata = valA; end
            4'h5:    ;
            4'h8:    begin cpu_we = 1'b1; cpu_wdata = valP; end
            4'h9:    cpu_addr = valA[ADDR_W-1:0];
            4'hA:    begin cpu_we = 1'b1; cpu_wdata = valA; end
            4'hB:    cpu_addr = valA[ADDR_W-1:0];
            default: begin cpu_mem = 1'b0; cpu_addr = '0; end
        endcase
    end

    // Round-robin arbitration: on a tie the side not granted last time wins
    always_comb begin
        grant_any = cpu_req | dbg_req;
        grant_dbg = dbg_req & (~cpu_req | (last_grant == 1'b0));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    if (!grant_dbg && !cpu_mem) state_nxt = S_DONE;
                    else                        state_nxt = S_CHECK;
                end
            end
            S_CHECK: state_nxt = (addr_q > ADDR_LIMIT) ? S_DONE : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mem_ready || cnt_q == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture, error/timeout tracking and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_dbg;
                        rdata_q    <= '0;
                        err_q      <= 1'b0;
                        if (grant_dbg) begin
                            addr_q  <= dbg_addr;
                            wdata_q <= dbg_we ? dbg_wdata : 64'd0;
                            we_q    <= dbg_we;
                        end else begin
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                            we_q    <= cpu_we;
                        end
                    end
                end
                S_CHECK: if (addr_q > ADDR_LIMIT) err_q <= 1'b1;
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    if (mem_ready) begin
                        if (!we_q) rdata_q <= mem_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; everything idles at 0
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_done  = 1'b0;
        cpu_err   = 1'b0;
        cpu_valM  = '0;
        dbg_done  = 1'b0;
        dbg_err   = 1'b0;
        dbg_rdata = '0;
        if (state == S_ISSUE || state == S_WAIT) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        if (state == S_DONE) begin
            if (last_grant) begin
                dbg_done  = 1'b1;
                dbg_err   = err_q;
                dbg_rdata = rdata_q;
            end else begin
                cpu_done  = 1'b1;
                cpu_err   = err_q;
                cpu_valM  = rdata_q;
            end
        end
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Sequencing and arbitration controller placed in front of the Y86 data memory.
- Decodes the CPU memory-stage request (icode, valE, valA, valP) into a read or write with the correct address and data.
- Shares the memory port round-robin with a debug/loader requester.
- Drives a request/ready handshake to a variable-latency memory, returns valM, and flags address errors (Y86 ADR status).

Parameters:
- ADDR_W, 64, width of byte address.
- MEM_BYTES, 4096, memory size in bytes; the valid 8-byte access range is addr <= MEM_BYTES-8.
- TIMEOUT, 16, maximum cycles to wait for mem_ready before aborting with error.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU memory-stage request; held high until cpu_done.
- icode  in  4  Y86 instruction code of the requesting instruction.
- valE  in  64  ALU result (address for rmmovq/mrmovq/call/push).
- valA  in  64  register A value (write data; address for ret/pop).
- valP  in  64  next PC (write data for call).
- cpu_valM  out  64  read data, valid while cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  address error or timeout, valid with cpu_done.
- dbg_req  in  1  debug request; held until dbg_done.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  64  debug byte address.
- dbg_wdata  in  64  debug write data.
- dbg_rdata  out  64  debug read data, valid with dbg_done.
- dbg_done  out  1  one-cycle completion pulse.
- dbg_err  out  1  error, valid with dbg_done.
- mem_en  out  1  memory access request.
- mem_we  out  1  write enable.
- mem_addr  out  64  access address.
- mem_wdata  out  64  write data.
- mem_rdata  in  64  read data, valid when mem_ready=1.
- mem_ready  in  1  memory completion, single-cycle pulse.

Behaviour:

Reset:
- All outputs reset to 0.
- State = IDLE; round-robin pointer last_grant = DBG, so the CPU wins the first tie.
- Reset mid-operation: return to IDLE next edge and drop mem_en; no done pulse is issued for the aborted operation.

CPU decode:
- 0x4 rmmovq: write, addr=valE, data=valA.
- 0x5 mrmovq: read, addr=valE.
- 0x8 call: write, addr=valE, data=valP.
- 0x9 ret: read, addr=valA.
- 0xA pushq: write, addr=valE, data=valA.
- 0xB popq: read, addr=valA.
- Any other icode with cpu_req: no memory access; cpu_done pulses 1 cycle after acceptance with cpu_err=0 and cpu_valM=0.

FSM states:
- IDLE:
  - Sample requests. If only one is pending, grant it. If both are pending, grant the requester that is not last_grant.
  - Latch the request's address, data and we into internal registers; inputs may change after the grant.
  - Update last_grant.
  - Next state: CHECK.
- CHECK:
  - If addr > MEM_BYTES-8 (unsigned, full 64-bit compare, no wrap), go to DONE with err=1 and no memory access.
  - Else go to ISSUE.
- ISSUE:
  - Assert mem_en, drive mem_we/mem_addr/mem_wdata from the latched values.
  - Clear the timeout counter.
  - Next state: WAIT.
- WAIT:
  - Hold mem_en and all mem_* outputs stable.
  - On mem_ready: capture mem_rdata (reads only), deassert mem_en, go to DONE.
  - Counter increments each cycle. When the count reaches TIMEOUT without mem_ready, deassert mem_en and go to DONE with err=1 and read data 0.
- DONE:
  - Pulse the granted requester's done/err/data for exactly 1 cycle.
  - Next state: IDLE.

Timing and boundaries:
- Minimum latency from request acceptance to done, with mem_ready on the first WAIT cycle: 4 cycles (IDLE→CHECK→ISSUE→WAIT→DONE).
- Back-to-back: a request still high in the IDLE cycle after DONE is re-arbitrated normally.
- A requester dropping req mid-operation does not cancel the operation; the done pulse is still generated.
- mem_ready outside WAIT is ignored.
- A write never updates cpu_valM or dbg_rdata; they read 0 on a write done.
- Starvation is impossible: with both requesters continuously pending, grants strictly alternate.

Test Plan:
- Reset, then cpu_req with icode=0x4, valE=0x100, valA=0xDEADBEEF, mem_ready on the first WAIT cycle → mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; cpu_done 4 cycles after acceptance, cpu_err=0.
- icode=0xB, valA=0x200, mem_rdata=0x1234 returned after a 3-cycle delay → mem_addr=0x200, mem_we=0; cpu_done with cpu_valM=0x1234.
- cpu_req and dbg_req asserted together from reset and held for 4 transactions → grant order CPU, DBG, CPU, DBG; never two consecutive grants to one side.
- icode=0x5, valE=MEM_BYTES-7 (0xFF9) → no mem_en pulse; cpu_done with cpu_err=1. valE=0xFF8 → normal access. valE=0xFFFFFFFFFFFFFFFF → error, no wrap.
- mem_ready never asserted → mem_en drops after 16 WAIT cycles; done pulses with err=1 and data 0. cpu_req with icode=0x6 → cpu_done with no mem_en at any point.
- rst asserted during WAIT → next cycle mem_en=0, all outputs 0, no done pulse; a new dbg_req after reset completes normally.
